// File: rtl/if_stage_r0.sv
// ---------------------------------------------------------------------------
// if_stage_r0
// Instruction fetch stage and IF/ID pipeline register for the 5-stage MIPS
// core. Owns the PC and talks to instruction memory over a req/gnt + rvalid
// handshake. At most one request is outstanding. A one-entry skid buffer
// holds a returning instruction while IF/ID is stalled. After a redirect,
// stale responses are thrown away.
//
// Ports:
//   clk          pipeline clock, all state on the rising edge
//   rst          asynchronous reset, active low
//   PC_write     hazard unit: 0 = hold PC, issue no new fetch
//   IDIF_write   hazard unit: 0 = hold IF/ID contents
//   flush        branch/jump taken in ID, redirect fetch to redirect_pc
//   redirect_pc  redirect target, valid while flush = 1
//   imem_req     fetch request valid
//   imem_addr    fetch address (the current pc)
//   imem_gnt     request accepted this cycle
//   imem_rvalid  response valid (earliest the cycle after gnt)
//   imem_rdata   returned instruction word
//   id_valid     IF/ID holds a live instruction
//   id_instr     IF/ID instruction
//   id_pc_plus4  address of id_instr + 4
// ---------------------------------------------------------------------------
module if_stage_r0 #(
    parameter int                   BIT_WIDTH = 32,
    parameter logic [BIT_WIDTH-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 PC_write,
    input  logic                 IDIF_write,
    input  logic                 flush,
    input  logic [BIT_WIDTH-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [BIT_WIDTH-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [BIT_WIDTH-1:0] imem_rdata,
    output logic                 id_valid,
    output logic [BIT_WIDTH-1:0] id_instr,
    output logic [BIT_WIDTH-1:0] id_pc_plus4
);

    // FETCH: nothing outstanding. WAIT: a live request is outstanding.
    // DRAIN: a stale request is outstanding, and its response is discarded.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [BIT_WIDTH-1:0] FOUR = BIT_WIDTH'(4);

    state_t               state;
    state_t               next_state;
    logic [BIT_WIDTH-1:0] pc;
    logic [BIT_WIDTH-1:0] req_pc;
    logic                 buf_valid;
    logic [BIT_WIDTH-1:0] buf_instr;
    logic [BIT_WIDTH-1:0] buf_pc4;
    logic                 accept;
    logic                 resp_live;
    logic                 drain_buf;

    assign imem_addr = pc;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Request generation and next-state logic.
    // A new request may go out in the same cycle that the previous response
    // lands, but only when that response can go straight into IF/ID.
    // Gating with rst keeps imem_req low while reset is held.
    // A response is "live" only in WAIT and only when no flush kills it.
    always_comb begin
        next_state = state;
        imem_req   = rst && !flush && PC_write && !buf_valid &&
                     ((state == FETCH) ||
                      ((state == WAIT) && imem_rvalid && IDIF_write));
        accept     = imem_req && imem_gnt;
        resp_live  = (state == WAIT) && imem_rvalid && !flush;
        drain_buf  = buf_valid && IDIF_write && !flush;

        if (flush) begin
            // A response that arrives with the flush is dropped. Otherwise
            // the outstanding request becomes stale and must be drained.
            case (state)
                WAIT:    next_state = imem_rvalid ? FETCH : DRAIN;
                DRAIN:   next_state = imem_rvalid ? FETCH : DRAIN;
                default: next_state = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    // A stray rvalid here is a protocol error and is ignored.
                    if (accept) begin
                        next_state = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        next_state = accept ? WAIT : FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        next_state = FETCH;
                    end
                end
                default: next_state = FETCH;
            endcase
        end
    end

    // PC and request-address tracking. req_pc remembers which address the
    // outstanding request was for, so its pc+4 can travel with the instr.
    // A flush redirects the PC and takes priority over an accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else if (flush) begin
            pc <= redirect_pc;
        end else if (accept) begin
            req_pc <= pc;
            pc     <= pc + FOUR;
        end
    end

    // Skid buffer: catches a live response that arrives while IF/ID is
    // stalled. It empties into IF/ID once the stall lifts. A flush kills it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_instr <= '0;
            buf_pc4   <= '0;
        end else if (flush) begin
            buf_valid <= 1'b0;
        end else if (resp_live && !IDIF_write) begin
            buf_valid <= 1'b1;
            buf_instr <= imem_rdata;
            buf_pc4   <= req_pc + FOUR;
        end else if (drain_buf) begin
            buf_valid <= 1'b0;
        end
    end

    // IF/ID register. When written, it takes a live response first, then
    // the skid buffer, and otherwise becomes a bubble. A bubble keeps the
    // old instr/pc4 bits and only clears valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc_plus4 <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (IDIF_write) begin
            if (resp_live) begin
                id_valid    <= 1'b1;
                id_instr    <= imem_rdata;
                id_pc_plus4 <= req_pc + FOUR;
            end else if (buf_valid) begin
                id_valid    <= 1'b1;
                id_instr    <= buf_instr;
                id_pc_plus4 <= buf_pc4;
            end else begin
                id_valid <= 1'b0;
            end
        end
    end

endmodule
